// File: rtl/gray_count_sched.sv
// rtl/gray_count_sched.sv - round-robin scheduler sharing one Gray-code counter among NREQ requesters
// Optional: define GRAY_COUNT_SCHED_PAUSE_EN to add a pause input that stalls RUN.
module gray_count_sched #(
    parameter int NREQ = 4,
    parameter int W    = 3,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
`ifdef GRAY_COUNT_SCHED_PAUSE_EN
    input  logic              pause,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      out,
    output logic [IDW-1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [W-1:0]      cnt, cnt_n, len_q, len_n, out_n, cnt_inc;
    logic [IDW-1:0]    last, last_n, owner_n, win;
    logic [NREQ-1:0]   gnt_n, done_n, req_sh, own_sh;
    logic [NREQ*W-1:0] len_sh;
    logic              busy_n, found, stall;
    int                idx;

`ifdef GRAY_COUNT_SCHED_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    // Search starts one past the last grant so the previous owner ranks lowest.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = 0;
        req_sh = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx    = (int'(last) + k) % NREQ;
            req_sh = req >> idx;
            if (!found && req_sh[0]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign own_sh  = req >> owner;
    assign len_sh  = len >> (int'(win) * W);
    assign cnt_inc = cnt + W'(1);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        done_n  = '0;
        busy_n  = busy;
        cnt_n   = cnt;
        out_n   = out;
        owner_n = owner;
        last_n  = last;
        len_n   = len_q;
        case (state)
            IDLE: begin
                gnt_n  = '0;
                busy_n = 1'b0;
                if (found) begin
                    owner_n = win;
                    last_n  = win;
                    len_n   = len_sh[W-1:0];
                    gnt_n   = NREQ'(1) << win;
                    cnt_n   = '0;
                    out_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!own_sh[0]) begin
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (stall) begin
                    state_n = RUN;
                end else if (cnt == len_q) begin
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = NREQ'(1) << owner;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_inc;
                    out_n = cnt_inc ^ (cnt_inc >> 1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Reset parks the pointer on the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            owner <= '0;
            last  <= IDW'(NREQ - 1);
            len_q <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            done  <= done_n;
            busy  <= busy_n;
            cnt   <= cnt_n;
            out   <= out_n;
            owner <= owner_n;
            last  <= last_n;
            len_q <= len_n;
        end
    end

endmodule

// File: tb/tb_gray_count_sched.sv
// tb/tb_gray_count_sched.sv - directed self-checking bench for gray_count_sched
module tb_gray_count_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] len;
    logic [3:0]  gnt, done;
    logic        busy;
    logic [2:0]  out;
    logic [1:0]  owner;
`ifdef GRAY_COUNT_SCHED_PAUSE_EN
    logic        pause;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] seq7 [0:6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101};
    logic [2:0] seq8 [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    int         rr_order [0:4] = '{0, 1, 2, 3, 0};

    gray_count_sched #(.NREQ(4), .W(3), .IDW(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
`ifdef GRAY_COUNT_SCHED_PAUSE_EN
        .pause (pause),
`endif
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .out   (out),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        len = {3'd1, 3'd1, 3'd1, 3'd1};
`ifdef GRAY_COUNT_SCHED_PAUSE_EN
        pause = 1'b0;
`endif
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_done", 32'(done), 32'h0);
            check("rst_out", 32'(out), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_owner", 32'(owner), 32'h0);
        end
        rst = 1'b0;

        // round-robin with every requester asking for len=1
        for (int r = 0; r < 5; r++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << rr_order[r]));
            check("rr_owner", 32'(owner), 32'(rr_order[r]));
            check("rr_busy", 32'(busy), 32'h1);
            check("rr_out0", 32'(out), 32'h0);
            tick();
            check("rr_out1", 32'(out), 32'b001);
            check("rr_done_early", 32'(done), 32'h0);
            tick();
            check("rr_done", 32'(done), 32'(4'b0001 << rr_order[r]));
            check("rr_gnt_off", 32'(gnt), 32'h0);
            check("rr_out_hold", 32'(out), 32'b001);
            tick();
            check("rr_dead_done", 32'(done), 32'h0);
            check("rr_dead_gnt", 32'(gnt), 32'h0);
            check("rr_dead_busy", 32'(busy), 32'h0);
        end
        req = 4'b0000;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // single run, len0=6
        req = 4'b0001;
        len = {3'd1, 3'd1, 3'd1, 3'd6};
        for (int i = 0; i < 7; i++) begin
            tick();
            check("run6_out", 32'(out), 32'(seq7[i]));
            check("run6_gnt", 32'(gnt), 32'b0001);
        end
        tick();
        check("run6_done", 32'(done), 32'b0001);
        check("run6_gnt_off", 32'(gnt), 32'h0);
        check("run6_out_hold", 32'(out), 32'b101);
        req = 4'b0000;
        tick();
        check("run6_done_off", 32'(done), 32'h0);
        check("run6_out_idle", 32'(out), 32'b101);

        // len2=0: single cycle at 000
        req = 4'b0100;
        len = {3'd1, 3'd0, 3'd1, 3'd1};
        tick();
        check("len0_gnt", 32'(gnt), 32'b0100);
        check("len0_owner", 32'(owner), 32'd2);
        check("len0_out", 32'(out), 32'h0);
        tick();
        check("len0_done", 32'(done), 32'b0100);
        check("len0_gnt_off", 32'(gnt), 32'h0);
        req = 4'b0000;
        tick();

        // len1=7: full range, len changed after grant is ignored
        req = 4'b0010;
        len = {3'd1, 3'd1, 3'd7, 3'd1};
        tick();
        check("len7_gnt", 32'(gnt), 32'b0010);
        check("len7_out", 32'(out), 32'(seq8[0]));
        len = {3'd1, 3'd1, 3'd2, 3'd1};
        for (int i = 1; i < 8; i++) begin
            tick();
            check("len7_out", 32'(out), 32'(seq8[i]));
            check("len7_done_early", 32'(done), 32'h0);
        end
        tick();
        check("len7_done", 32'(done), 32'b0010);
        check("len7_out_top", 32'(out), 32'b100);
        req = 4'b0000;
        tick();

        // abandon: requester 3 granted while requester 0 waits
        req = 4'b1001;
        len = {3'd6, 3'd1, 3'd1, 3'd1};
        tick();
        check("ab_gnt", 32'(gnt), 32'b1000);
        check("ab_owner", 32'(owner), 32'd3);
        tick();
        check("ab_out1", 32'(out), 32'b001);
        tick();
        check("ab_out2", 32'(out), 32'b011);
        req = 4'b0001;
        tick();
        check("ab_gnt_off", 32'(gnt), 32'h0);
        check("ab_no_done", 32'(done), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_out_hold", 32'(out), 32'b011);
        tick();
        check("ab_next_gnt", 32'(gnt), 32'b0001);
        check("ab_next_owner", 32'(owner), 32'd0);
        check("ab_next_out", 32'(out), 32'h0);
        req = 4'b0000;
        tick();
        check("ab2_gnt_off", 32'(gnt), 32'h0);
        check("ab2_no_done", 32'(done), 32'h0);
        tick();

`ifdef GRAY_COUNT_SCHED_PAUSE_EN
        req = 4'b0001;
        len = {3'd1, 3'd1, 3'd1, 3'd3};
        tick();
        check("p_out0", 32'(out), 32'b000);
        tick();
        check("p_out1", 32'(out), 32'b001);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p_hold", 32'(out), 32'b001);
            check("p_gnt", 32'(gnt), 32'b0001);
        end
        pause = 1'b0;
        tick();
        check("p_out2", 32'(out), 32'b011);
        tick();
        check("p_out3", 32'(out), 32'b010);
        check("p_done_early", 32'(done), 32'h0);
        tick();
        check("p_done", 32'(done), 32'b0001);
        req = 4'b0000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_count_sched.md
Name: gray_count_sched

Overview:
- Round-robin scheduler that shares one internal Gray-code counter between NREQ requesters.
- Each requester asks for a counting run of programmable length.
  - The scheduler grants one requester at a time.
  - It sequences the counter through Gray values 0..len, then pulses that requester's done.
- Sits above the Gray counter datapath; replaces ad-hoc enable/rst driving from multiple sources.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 3, counter width in bits; Gray output width
- IDW, 2, owner index width, must be >= clog2(NREQ)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level; held high until done or abandoned
- len  input  NREQ*W  packed run lengths; requester i uses len[i*W +: W]
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle completion pulse, registered
- busy  output  1  high while a run is active (state RUN)
- out  output  W  Gray-coded count, registered
- owner  output  IDW  index of current/last granted requester

Behaviour:
- Reset (rst high at an edge): all outputs are 0.
  - The state goes to IDLE.
  - The round-robin pointer resets so requester 0 has highest priority.
  - Reset mid-run aborts silently: no done pulse.
- States are IDLE, RUN and DONE. Internal binary count cnt[W-1:0]; out = cnt ^ (cnt >> 1), registered together with cnt.
- IDLE:
  - gnt = 0 and busy = 0.
  - out and owner hold their last values.
  - If any req bit is high at an edge, on that edge:
    - Select the winner by round-robin, starting at (last_owner+1) mod NREQ.
    - Latch len of the winner into len_q.
    - Set gnt to the winner's one-hot, owner = winner index, cnt = 0, out = 0, busy = 1.
    - State goes to RUN.
  - Grant latency is 1 edge after req is first sampled.
- RUN:
  - Each edge:
    - If req[owner] is low, abandon: gnt = 0, busy = 0, no done, go to IDLE. cnt and out hold their values.
    - Else if cnt == len_q, gnt = 0, busy = 0, done[owner] = 1, go to DONE. out holds the final Gray value.
    - Else increment cnt; out advances one Gray step.
  - A run therefore shows len_q+1 Gray values (0 through gray(len_q)), each for exactly one cycle.
  - len_q = 0 gives one cycle of out = 0.
  - len_q = 2^W-1 counts to the top; it never wraps inside a run.
- DONE:
  - Lasts exactly one cycle; done is low again after the next edge.
  - The next edge goes to IDLE, so there is one dead cycle between runs.
  - Requests are not sampled in DONE.
- Round-robin:
  - last_owner updates on every grant.
  - The finishing or abandoning requester has lowest priority in the next arbitration.
- Boundary conditions:
  - Changes to len[i] after grant are ignored, because the length is latched.
  - req of non-owners during RUN is ignored; those requests wait.
  - Several simultaneous new requests are granted in round-robin order, one run each.
  - A requester holding req high after done re-enters arbitration at lowest priority.
- Invariants:
  - gnt is one-hot or zero.
  - done is never concurrent with gnt for the same requester.
  - Adjacent out values in a run differ in exactly one bit.

Optional Feature:
- Macro GRAY_COUNT_SCHED_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - While pause is high in RUN, cnt and out hold and the terminal check is suppressed.
  - The req-abandon check still applies.
  - pause has no effect in IDLE or DONE.
- Undefined: no pause port; RUN advances every cycle as above.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, done=0, out=000, busy=0, owner=0 throughout; first grant after rst falls goes to requester 0.
- Single run: req=4'b0001, len0=6 -> gnt=0001 one edge later; out sequence 000,001,011,010,110,111,101 (7 cycles); then done=0001 for 1 cycle, gnt=0; out holds 101.
- Round-robin: req=4'b1111, all len=1 -> grants in order 0,1,2,3,0; each run is 2 out cycles + DONE + IDLE = 4 cycles apart; done pulses in the same order.
- len=0 and max: len2=0 -> one RUN cycle at out=000 then done[2]; len1=7 -> 8 values ending at 100, no wrap.
- Abandon: requester 3 granted with len=6; drop req[3] when out=011 -> gnt=0 next edge, no done[3], out holds 011; pending req[0] is granted on the following edge.
- Pause (with GRAY_COUNT_SCHED_PAUSE_EN): len0=3, pause high 3 cycles when out=001 -> out stays 001 for 4 cycles total; resumes 011,010; done[0] is delayed by 3 cycles.
